// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared state encoding and gate truth-table constants
package gate_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  // Bit i is the gate response expected for input vector i ({a,b}, a = MSB).
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable incrementing counter that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // clear wins over inc; once all-ones the count no longer moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - exhaustive stimulus sweep and response check for a combinational gate
module gate_vector_checker
  import gate_check_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter logic [(2**N_IN)-1:0]  TRUTH  = TT_AND,
  parameter int                    SETTLE = 2,
  parameter int                    ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  output logic [N_IN-1:0]  vec_out,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec
);

  // Settle counter runs 0..SETTLE-1 in WAIT; keep at least one bit when SETTLE is 0 or 1.
  localparam int              SW            = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int              SETTLE_LAST_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [SW-1:0]   SETTLE_LAST   = SETTLE_LAST_I[SW-1:0];

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic          exp_bit;
  logic          mismatch;
  logic          last_vec;
  logic          sweep_start;
  logic          err_clear;
  logic          err_inc;

  // vec_out doubles as the vector counter: it only advances on SAMPLE->DRIVE
  // and is reloaded to 0 only when a new sweep starts.
  assign exp_bit     = TRUTH[vec_out];
  // Case inequality so an unknown or floating gate output is reported as a mismatch.
  assign mismatch    = (dut_out !== exp_bit);
  assign last_vec    = (vec_out == {N_IN{1'b1}});
  assign sweep_start = start && ((state == IDLE) || (state == DONE));
  assign err_clear   = stop || sweep_start;
  assign err_inc     = !stop && (state == SAMPLE) && mismatch;

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (err_clear),
    .inc   (err_inc),
    .count (err_cnt)
  );

  // Sweep sequencer: drive a vector, let the gate settle, sample, advance; stop overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      vec_out         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (stop) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      vec_out         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= DRIVE;
            settle_cnt      <= '0;
            vec_out         <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
          end
        end

        DRIVE: begin
          settle_cnt <= '0;
          if (SETTLE == 0) begin
            state <= SAMPLE;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        SAMPLE: begin
          if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= vec_out;
          end
          if (last_vec) begin
            // err_cnt has not yet absorbed this sample, so fold it in here.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0) && !mismatch;
          end else begin
            state   <= DRIVE;
            vec_out <= vec_out + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
